// File: rtl/count_snapshot_fifo.sv
// Counter snapshot FIFO: captures count on snap into a small FWFT queue.
// Optional build macro COUNT_SNAPSHOT_DELTA_EN stores deltas from the previous accepted capture.

// Generic FWFT FIFO with synchronous flush and explicit occupancy.
// Latency: a push on edge N is visible at head_dat after edge N when empty.
// Backpressure: caller must not push when full unless it also pops in the same cycle.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_vld,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     lvl
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    lvl_q;

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl_q  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl_q  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_vld, pop_vld})
                2'b10:   lvl_q <= lvl_q + LW'(1);
                2'b01:   lvl_q <= lvl_q - LW'(1);
                default: lvl_q <= lvl_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld && !clr) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign head_dat = mem[rd_ptr];
    assign lvl      = lvl_q;
endmodule

// Snapshot capture front end: accepts snap strobes into the FIFO, flags drops.
// Latency: 1 cycle from accepted snap to out_valid/out_data.
// Backpressure: out_ready=0 holds the head; captures when full without a pop are dropped and set overflow.
module count_snapshot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           count,
    input  logic                       snap,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             full;
    logic             pop_vld;
    logic             push_vld;
    logic [WIDTH-1:0] push_dat;
    logic [LW-1:0]    lvl;
    logic             ovf_q;

    assign full      = (lvl == LW'(DEPTH));
    assign out_valid = (lvl != '0);
    assign pop_vld   = out_valid && out_ready && !clear;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_vld  = snap && !clear && (!full || pop_vld);

`ifdef COUNT_SNAPSHOT_DELTA_EN
    logic [WIDTH-1:0] base_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
        end else if (clear) begin
            base_q <= '0;
        end else if (push_vld) begin
            base_q <= count;
        end
    end

    assign push_dat = count - base_q;
`else
    assign push_dat = count;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (clear) begin
            ovf_q <= 1'b0;
        end else if (snap && !push_vld) begin
            ovf_q <= 1'b1;
        end
    end

    fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clear),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (out_data),
        .lvl      (lvl)
    );

    assign level    = lvl;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench for count_snapshot_fifo (WIDTH=8, DEPTH=4); expectations follow the build macro.
module tb_count_snapshot_fifo;
    logic       clk;
    logic       rst_n;
    logic [7:0] count;
    logic       snap;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    count_snapshot_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count     (count),
        .snap      (snap),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_snap(input logic [7:0] c);
        count = c;
        snap  = 1'b1;
        tick();
        snap  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

`ifdef COUNT_SNAPSHOT_DELTA_EN
    localparam bit DELTA = 1'b1;
`else
    localparam bit DELTA = 1'b0;
`endif

    initial begin
        logic [7:0] exp_q [$];

        rst_n = 1'b0; count = '0; snap = 1'b0; clear = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset_level", 32'(level), 0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_ovf", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // First capture, one cycle latency
        do_snap(8'h05);
        chk("first_valid", 32'(out_valid), 1);
        chk("first_data", 32'(out_data), 32'h05);
        chk("first_level", 32'(level), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("first_drain_valid", 32'(out_valid), 0);
        do_clear();

        // Fill past capacity with the consumer stalled
        for (int i = 1; i <= 5; i++) begin
            do_snap(8'(i));
            chk($sformatf("fill_level_%0d", i), 32'(level), (i > 4) ? 4 : i);
            chk($sformatf("fill_ovf_%0d", i), 32'(overflow), (i > 4) ? 1 : 0);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_valid_%0d", i), 32'(out_valid), 1);
            chk($sformatf("drain_data_%0d", i), 32'(out_data), DELTA ? 1 : i);
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 0);
        chk("drain_ovf_sticky", 32'(overflow), 1);
        do_clear();
        chk("clear_ovf", 32'(overflow), 0);

        // Full FIFO, capture with simultaneous pop
        for (int i = 0; i < 4; i++) do_snap(8'h11 + 8'(i));
        chk("full_level", 32'(level), 4);
        chk("full_head", 32'(out_data), 32'h11);
        count = 8'h09; snap = 1'b1; out_ready = 1'b1;
        tick();
        snap = 1'b0;
        chk("cap_pop_level", 32'(level), 4);
        chk("cap_pop_ovf", 32'(overflow), 0);
        if (DELTA) begin
            exp_q.push_back(8'h01); exp_q.push_back(8'h01);
            exp_q.push_back(8'h01); exp_q.push_back(8'hF5);
        end else begin
            exp_q.push_back(8'h12); exp_q.push_back(8'h13);
            exp_q.push_back(8'h14); exp_q.push_back(8'h09);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cap_pop_data_%0d", i), 32'(out_data), 32'(exp_q[i]));
            tick();
        end
        out_ready = 1'b0;
        chk("cap_pop_empty", 32'(out_valid), 0);
        do_clear();

        // Wrap-around in delta mode
        do_snap(8'hF0);
        do_snap(8'h10);
        chk("wrap_level", 32'(level), 2);
        chk("wrap_data_0", 32'(out_data), 32'hF0);
        out_ready = 1'b1;
        tick();
        chk("wrap_data_1", 32'(out_data), DELTA ? 32'h20 : 32'h10);
        tick();
        out_ready = 1'b0;
        chk("wrap_empty", 32'(out_valid), 0);

        // Clear beats snap and pop
        for (int i = 1; i <= 5; i++) do_snap(8'h40 + 8'(i));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pre_clear_level", 32'(level), 3);
        chk("pre_clear_ovf", 32'(overflow), 1);
        clear = 1'b1; snap = 1'b1; out_ready = 1'b1; count = 8'hAA;
        tick();
        clear = 1'b0; snap = 1'b0; out_ready = 1'b0;
        chk("clr_level", 32'(level), 0);
        chk("clr_valid", 32'(out_valid), 0);
        chk("clr_ovf", 32'(overflow), 0);
        do_snap(8'h07);
        chk("post_clr_data", 32'(out_data), 32'h07);
        chk("post_clr_level", 32'(level), 1);

        // Asynchronous reset between edges
        do_snap(8'h08);
        chk("pre_rst_level", 32'(level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_level", 32'(level), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(out_valid), 0);
        do_snap(8'h33);
        chk("post_rst_data", 32'(out_data), 32'h33);
        chk("post_rst_level", 32'(level), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/count_snapshot_fifo.md
COUNT_SNAPSHOT_FIFO -- requirements
Module: count_snapshot_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the sampled counter value and of stored entries.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port count  input  WIDTH  free-running counter value from the upstream counter stage.
REQ-006 SHALL have port snap  input  1  capture strobe; a high level on a rising edge requests one capture.
REQ-007 SHALL have port clear  input  1  synchronous flush of FIFO, overflow flag and delta baseline.
REQ-008 SHALL have port out_valid  output  1  head entry available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port out_data  output  WIDTH  head entry.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  number of stored entries, range 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky flag: a capture was dropped.

Function
REQ-013 SHALL treat a capture as accepted when snap=1, clear=0, and either level<DEPTH or a pop occurs in the same cycle.
REQ-014 SHALL write count as sampled on that edge into the tail entry on each accepted capture.
REQ-015 SHALL define a pop as out_valid=1 and out_ready=1 on a rising edge, with clear=0; a pop removes the head entry.
REQ-016 SHALL drive out_valid=1 exactly when level!=0; out_data is the head entry, first-word fall-through.
REQ-017 SHALL have a latency of 1 cycle: a capture on edge N gives out_valid=1 and valid out_data after edge N if the FIFO was empty.
REQ-018 SHALL make level increase by 1 on a capture only, decrease by 1 on a pop only, and stay unchanged on a simultaneous capture and pop.
REQ-019 SHALL, on a capture when full with no pop: drop the sample, leave FIFO contents and level unchanged, and set overflow=1.
REQ-020 SHALL hold overflow at 1 until clear or reset; captures and pops do not clear it.
REQ-021 SHALL wrap read and write pointers modulo DEPTH; level distinguishes full from empty.
REQ-022 SHALL give clear=1 priority over snap and pop in the same cycle: level->0, overflow->0, delta baseline->0, no write, no pop.
REQ-023 SHALL make out_data undefined-but-stable when out_valid=0; consumers do not sample it in that state.
REQ-024 SHALL leave out_data unchanged while out_valid=1 and out_ready=0, and SHALL NOT let later captures alter the head entry.

Reset
REQ-025 SHALL, while rst_n=0 (independent of clk), set: level=0, out_valid=0, overflow=0, pointers=0, delta baseline=0.
REQ-026 SHALL treat FIFO storage contents as don't-care after reset; out_data=0 is not required.
REQ-027 SHALL discard all stored entries and in-flight captures when reset asserts mid-operation; operation restarts on the first edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with COUNT_SNAPSHOT_DELTA_EN defined, store on an accepted capture (count - baseline) mod 2^WIDTH, then load baseline with count.
REQ-029 SHALL update the baseline only on accepted captures, not dropped ones, so stored deltas sum to the total advance of the accepted samples.
REQ-030 SHALL, with COUNT_SNAPSHOT_DELTA_EN undefined, store the raw count and contain no baseline register; ports are identical in both builds.

Verification (WIDTH=8, DEPTH=4)
REQ-031 SHALL cover: reset, snap with count=0x05 -> next cycle out_valid=1, out_data=0x05 in both builds, level=1.
REQ-032 SHALL cover: out_ready=0, five snaps with count=1..5 -> level=4, overflow=1 after the 5th; draining with out_ready=1 yields 1,2,3,4 (raw), then out_valid=0.
REQ-033 SHALL cover: full FIFO, snap with count=0x09 plus pop in the same cycle -> capture accepted, level stays 4, overflow stays 0, 0x09 is the last entry.
REQ-034 SHALL cover: DELTA_EN build, snaps at count=0xF0 then 0x10 -> entries 0xF0, 0x20 (wrap-around).
REQ-035 SHALL cover: level=3, overflow=1, clear+snap+out_ready in one cycle -> next cycle level=0, out_valid=0, overflow=0; the next snap at 0x07 stores 0x07 in both builds.
REQ-036 SHALL cover: rst_n pulsed low between clock edges with level=2 -> out_valid=0 and level=0 immediately, no clock required.
